// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core, with W->D write-through
// bypass, load-use stall, branch/jump flush and EX operand forwarding selects.

module id_ex_bypass #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [4:0]      rd_w,
    input  logic            reg_write_w,
    input  logic [XLEN-1:0] rd_data,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] q
);
    // The register file writes on the edge but reads combinationally, so a same-cycle
    // WB write must be picked up here or decode would capture the stale value.
    assign q = (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) ? result_w : rd_data;
endmodule

module id_ex_fwd_sel (
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       valid_e,
    output logic [1:0] fwd
);
    always_comb begin
        fwd = 2'b00;
        if (valid_e) begin
            if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e))
                fwd = 2'b10;
            else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e))
                fwd = 2'b01;
        end
    end
endmodule

module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [10:0]     CtrlD,
    input  logic            PCSrcE,
    input  logic [4:0]      RdM,
    input  logic            RegWriteM,
    input  logic [4:0]      RdW,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [10:0]     CtrlE,
    output logic            ValidE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [NUM_OPS-1:0][XLEN-1:0] rd;
        logic [XLEN-1:0]              imm;
        logic [XLEN-1:0]              pc;
        logic [XLEN-1:0]              pc_plus4;
        logic [4:0]                   rd_addr;
        logic [NUM_OPS-1:0][4:0]      rs;
        logic [10:0]                  ctrl;
        logic                         valid;
    } ex_reg_t;

    logic [NUM_OPS-1:0][XLEN-1:0] rd_d;
    logic [NUM_OPS-1:0][XLEN-1:0] rd_byp;
    logic [NUM_OPS-1:0][4:0]      rs_d;
    logic [NUM_OPS-1:0][1:0]      fwd;
    ex_reg_t                      ex_d;
    ex_reg_t                      ex_q;
    logic                         lw_stall;
    logic                         flush_e;

    assign rd_d = {RD2D, RD1D};
    assign rs_d = {Rs2D, Rs1D};

    // Operand 0 is A (rs1), operand 1 is B (rs2).
    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        id_ex_bypass #(.XLEN(XLEN)) u_byp (
            .rs          (rs_d[g]),
            .rd_w        (RdW),
            .reg_write_w (RegWriteW),
            .rd_data     (rd_d[g]),
            .result_w    (ResultW),
            .q           (rd_byp[g])
        );
        id_ex_fwd_sel u_fwd (
            .rs_e        (ex_q.rs[g]),
            .rd_m        (RdM),
            .rd_w        (RdW),
            .reg_write_m (RegWriteM),
            .reg_write_w (RegWriteW),
            .valid_e     (ex_q.valid),
            .fwd         (fwd[g])
        );
    end

    assign lw_stall = (ex_q.ctrl[9:8] == 2'b01) && ex_q.valid && (ex_q.rd_addr != 5'd0) &&
                      ((ex_q.rd_addr == Rs1D) || (ex_q.rd_addr == Rs2D));
    assign flush_e  = lw_stall || PCSrcE;

    always_comb begin
        ex_d          = '0;
        ex_d.rd       = rd_byp;
        ex_d.imm      = ImmExtD;
        ex_d.pc       = PCD;
        ex_d.pc_plus4 = PCPlus4D;
        ex_d.rd_addr  = RdD;
        ex_d.rs       = rs_d;
        ex_d.ctrl     = CtrlD;
        ex_d.valid    = 1'b1;
    end

    // EX never holds: a stall or redirect turns the slot into an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || flush_e)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign RD1E      = ex_q.rd[0];
    assign RD2E      = ex_q.rd[1];
    assign RdE       = ex_q.rd_addr;
    assign ImmExtE   = ex_q.imm;
    assign PCE       = ex_q.pc;
    assign PCPlus4E  = ex_q.pc_plus4;
    assign CtrlE     = ex_q.ctrl;
    assign ValidE    = ex_q.valid;
    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];
    assign StallF    = lw_stall;
    assign StallD    = lw_stall;
    assign FlushD    = PCSrcE;
endmodule
